// File: rtl/elevator_call_scheduler.sv
// SCAN-policy call scheduler: latches floor calls, picks the next target floor,
// hands it to the car controller and holds the doors for a fixed dwell.
`timescale 1ns/1ps
module elevator_call_scheduler #(
  parameter int NUM_FLOORS   = 8,
  parameter int FLOOR_W      = 3,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  arrived,
  input  logic                  over_weight,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  target_valid,
  output logic [1:0]            direction,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);
  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [1:0] DIR_IDLE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DOWN = 2'd2;

  typedef enum logic [1:0] {IDLE, SELECT, DISPATCH, SERVE} state_t;

  state_t                  state_q, state_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [FLOOR_W-1:0]      target_q, target_d;
  logic                    valid_q, valid_d;
  logic [1:0]              dir_q, dir_d;
  logic                    door_q, door_d;
  logic [CNT_W-1:0]        dwell_q, dwell_d;

  logic [NUM_FLOORS-1:0]   cur_onehot;
  logic [NUM_FLOORS-1:0]   clear_mask;
  logic                    cur_hit;
  logic                    above_found, below_found, between_found;
  logic [FLOOR_W-1:0]      above_floor, below_floor, between_floor;

  // Out-of-range cur_floor never matches any bit, so it can never clear a request.
  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
    assign cur_onehot[gi] = (cur_floor == FLOOR_W'(gi));
    assign clear_mask[gi] = (state_q == SERVE) && cur_onehot[gi];
  end

  assign cur_hit = |(pending_q & cur_onehot);

  // Nearest pending floor above / below the car, and the nearest one lying
  // strictly between the car and its current target in the travel direction.
  always_comb begin
    above_found   = 1'b0;
    above_floor   = '0;
    below_found   = 1'b0;
    below_floor   = '0;
    between_found = 1'b0;
    between_floor = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && i > int'(cur_floor)) begin
        above_found = 1'b1;
        above_floor = FLOOR_W'(i);
        if (dir_q == DIR_UP && i < int'(target_q)) begin
          between_found = 1'b1;
          between_floor = FLOOR_W'(i);
        end
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && i < int'(cur_floor)) begin
        below_found = 1'b1;
        below_floor = FLOOR_W'(i);
        if (dir_q == DIR_DOWN && i > int'(target_q)) begin
          between_found = 1'b1;
          between_floor = FLOOR_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    valid_d   = valid_q;
    dir_d     = dir_q;
    door_d    = door_q;
    dwell_d   = dwell_q;
    pending_d = (pending_q | call_btn) & ~clear_mask;
    if (over_weight) begin
      if (state_q == DISPATCH) valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          dir_d   = DIR_IDLE;
          valid_d = 1'b0;
          if (|pending_q) state_d = SELECT;
        end
        SELECT: begin
          if (!(|pending_q)) begin
            state_d = IDLE;
            dir_d   = DIR_IDLE;
          end else begin
            state_d = DISPATCH;
            valid_d = 1'b1;
            if (cur_hit) begin
              target_d = cur_floor;
            end else if (dir_q == DIR_DOWN) begin
              target_d = below_found ? below_floor : above_floor;
              dir_d    = below_found ? DIR_DOWN : DIR_UP;
            end else begin
              target_d = above_found ? above_floor : below_floor;
              dir_d    = above_found ? DIR_UP : DIR_DOWN;
            end
          end
        end
        DISPATCH: begin
          valid_d = 1'b1;
          if (arrived && cur_floor == target_q) begin
            state_d = SERVE;
            valid_d = 1'b0;
            door_d  = 1'b1;
            dwell_d = CNT_W'(DWELL_CYCLES - 1);
          end else if (!arrived && between_found) begin
            target_d = between_floor;
          end
        end
        SERVE: begin
          door_d = 1'b1;
          if (dwell_q == '0) begin
            state_d = SELECT;
            door_d  = 1'b0;
          end else begin
            dwell_d = dwell_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      target_q  <= '0;
      valid_q   <= 1'b0;
      dir_q     <= DIR_IDLE;
      door_q    <= 1'b0;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      valid_q   <= valid_d;
      dir_q     <= dir_d;
      door_q    <= door_d;
      dwell_q   <= dwell_d;
    end
  end

  assign target_floor = target_q;
  assign target_valid = valid_q;
  assign direction    = dir_q;
  assign door_open    = door_q;
  assign pending      = pending_q;
endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
- Upstream stage of the elevator car controller.
- Latches hall/cab floor-call buttons into a pending-request bitmap.
- Picks the next target floor with a directional (SCAN) policy and presents it to the car controller through a valid/arrive handshake.
- Holds the doors at each served floor for a fixed dwell, then clears that request and re-schedules.

Parameters:
- NUM_FLOORS, 8, number of floors; floors are 0..NUM_FLOORS-1, all valid targets.
- FLOOR_W, 3, width of floor indices (clog2 of NUM_FLOORS).
- DWELL_CYCLES, 4, clock cycles the car stays at a served floor before rescheduling (>=1).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- call_btn  input  NUM_FLOORS  per-floor call request, bit f = floor f; level or pulse, sampled every clk.
- cur_floor  input  FLOOR_W  current car floor from the car controller.
- arrived  input  1  car controller reports it is stopped at cur_floor (1-cycle pulse or level).
- over_weight  input  1  car overload flag; freezes dispatch.
- target_floor  output  FLOOR_W  floor the car must travel to; stable while target_valid=1, except for en-route retarget.
- target_valid  output  1  target_floor is a live request.
- direction  output  2  0=idle, 1=up, 2=down; 3 never driven.
- door_open  output  1  high during dwell at a served floor.
- pending  output  NUM_FLOORS  registered pending-request bitmap.

Behaviour:
- Reset, asynchronous, active-high: state=IDLE, pending=0, target_floor=0, target_valid=0, direction=0, door_open=0, dwell counter=0. A reset mid-operation drops every pending request.
- Request latching: each clk, pending <= (pending | call_btn) & ~clear_mask.
  - clear_mask has only bit cur_floor set, and only while in SERVE.
  - A press at cur_floor during SERVE is absorbed; the door is already open.
  - A press at any other floor during SERVE latches normally.
- FSM states: IDLE, SELECT, DISPATCH, SERVE.
- IDLE: direction=0, target_valid=0.
  - If pending!=0, go to SELECT.
- SELECT (1 cycle): register target_floor and direction, then go to DISPATCH.
  - If pending[cur_floor]=1, target=cur_floor and direction is unchanged.
  - If direction=up (or idle), target = lowest pending floor > cur_floor, direction=up.
  - If none above, target = highest pending floor < cur_floor, direction=down.
  - If direction=down, apply the mirror image of the up rule.
  - From idle with requests at equal distance above and below, prefer up.
  - If pending==0 (all cleared), go to IDLE with direction=0.
- Latency: a call latched at edge N while in IDLE gives SELECT at N+1 and target_valid=1 after edge N+2.
- DISPATCH: target_valid=1.
  - If arrived=1 and cur_floor==target_floor, go to SERVE, target_valid<=0, door_open<=1, dwell counter<=DWELL_CYCLES-1.
  - En-route retarget: if arrived=0 and a pending floor lies strictly between cur_floor and target_floor in the current direction, target_floor <= the nearest such floor on the next cycle. Retarget never happens in a cycle where arrived=1.
  - arrived=1 at a floor other than target_floor is ignored.
- SERVE: door_open=1, pending[cur_floor] is cleared, dwell counter decrements each cycle.
  - At count 0, go to SELECT with door_open<=0.
- over_weight=1 freezes the FSM in its current state.
  - In DISPATCH, target_valid is forced to 0.
  - In SERVE, the dwell counter holds and door_open stays 1.
  - Pending latching continues during the freeze.
  - When over_weight falls, operation resumes from the frozen state with the same target.
- Widths: floor comparisons are unsigned on FLOOR_W bits. call_btn bits >= NUM_FLOORS do not exist. cur_floor values >= NUM_FLOORS never set clear_mask.
- Boundaries:
  - At top floor going up with no requests above, reverse to down.
  - At floor 0 going down, reverse to up.
  - A press and a clear on the same floor in the same cycle outside SERVE cannot occur; clears happen only in SERVE.

Test Plan:
- Reset, then single call: rst pulse, cur_floor=0, call_btn=8'b0010_0000 for 1 cycle -> target_floor=5, direction=1, target_valid=1 two cycles later; arrived with cur_floor=5 -> door_open high exactly 4 cycles, pending[5]=0, then IDLE with direction=0.
- SCAN order: cur_floor=3, direction up, pending floors 1,6,7 -> targets served in order 6, 7, 1; direction goes 1,1,2.
- En-route pickup: target=7 from floor 2, press floor 4 while the car is at floor 3 -> target_floor changes to 4 next cycle; after serving 4, target returns to 7.
- Call at current floor: idle at floor 2, press floor 2 -> SERVE with door_open=1 and no travel; pressing 2 again during dwell leaves pending[2]=0.
- Overweight freeze: assert over_weight in DISPATCH with target=6 -> target_valid=0 and the state holds; a press on floor 1 still sets pending[1]; deassert -> target_valid=1 with target_floor=6.
- Async reset mid-SERVE: rst asserted between edges -> all outputs 0 immediately, pending=0.
